// File: rtl/mac_pkg.sv
// Shared types, defaults and width helper for the vector MAC unit.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } mac_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LANES      = 4;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_LEN_WIDTH  = 8;

    // Width of the lane-product adder tree output.
    function automatic int red_width(input int data_width, input int lanes);
        return 2 * data_width + $clog2(lanes);
    endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One registered unsigned lane multiplier with a valid bit (pipeline stage 1).
module mac_lane_mult
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] prod,
    output logic                    prod_valid
);

    logic [2*DATA_WIDTH-1:0] prod_r;
    logic                    prod_valid_r;
    logic [2*DATA_WIDTH-1:0] a_ext_s;
    logic [2*DATA_WIDTH-1:0] b_ext_s;

    assign a_ext_s = {{DATA_WIDTH{1'b0}}, a};
    assign b_ext_s = {{DATA_WIDTH{1'b0}}, b};

    // Product and valid register; clr discards any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r       <= {(2*DATA_WIDTH){1'b0}};
            prod_valid_r <= 1'b0;
        end else if (clr) begin
            prod_r       <= {(2*DATA_WIDTH){1'b0}};
            prod_valid_r <= 1'b0;
        end else begin
            prod_r       <= a_ext_s * b_ext_s;
            prod_valid_r <= in_valid;
        end
    end

    assign prod       = prod_r;
    assign prod_valid = prod_valid_r;

endmodule

// File: rtl/mac_vector_unit.sv
// Multi-lane dot-product accumulator: operand capture, lane multipliers, adder tree, FSM.
// Optional build macro MAC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module mac_vector_unit
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [LEN_WIDTH-1:0]          len,
    output logic                          start_ready,
    input  logic                          Clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   Ain,
    input  logic [LANES*DATA_WIDTH-1:0]   Bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          Cout,
    output logic                          overflow
);

    localparam int RED_W = red_width(DATA_WIDTH, LANES);

    mac_state_e                  state_r, next_state_s;
    logic [LEN_WIDTH-1:0]        cnt_r;
    logic                        beat_v_r;
    logic [LANES*DATA_WIDTH-1:0] a_r, b_r;
    logic [ACC_WIDTH-1:0]        acc_r, acc_next_s, cout_r;
    logic                        ovf_r, ovf_next_s;
    logic                        start_ready_r, in_ready_r, out_valid_r;
    logic [2*DATA_WIDTH-1:0]     prod_s [LANES];
    logic [LANES-1:0]            prod_v_s;
    logic [RED_W-1:0]            tree_s;
    logic [ACC_WIDTH:0]          sum_s;
    logic                        accept_s, start_go_s;

    assign accept_s   = in_valid && in_ready_r;
    assign start_go_s = (state_r == IDLE) && start;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_lane_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (Clr),
            .in_valid   (beat_v_r),
            .a          (a_r[g*DATA_WIDTH +: DATA_WIDTH]),
            .b          (b_r[g*DATA_WIDTH +: DATA_WIDTH]),
            .prod       (prod_s[g]),
            .prod_valid (prod_v_s[g])
        );
    end

    // Stage 2: reduce lane products and fold them into the accumulator.
    always_comb begin
        tree_s = {RED_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            tree_s = tree_s + RED_W'(prod_s[i]);
        end
        sum_s      = {1'b0, acc_r} + (ACC_WIDTH+1)'(tree_s);
        acc_next_s = acc_r;
        ovf_next_s = ovf_r;
        if (|prod_v_s) begin
            ovf_next_s = ovf_r | sum_s[ACC_WIDTH];
`ifdef MAC_SATURATE_EN
            if (ovf_next_s) begin
                acc_next_s = {ACC_WIDTH{1'b1}};
            end else begin
                acc_next_s = sum_s[ACC_WIDTH-1:0];
            end
`else
            acc_next_s = sum_s[ACC_WIDTH-1:0];
`endif
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Next-state logic; Clr overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        if (Clr) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        next_state_s = (len == {LEN_WIDTH{1'b0}}) ? DONE : ACCUM;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                ACCUM: begin
                    if (accept_s && (cnt_r == LEN_WIDTH'(1'b1))) begin
                        next_state_s = FLUSH;
                    end else begin
                        next_state_s = ACCUM;
                    end
                end
                // Leave when the last product is being accumulated on this edge.
                FLUSH: begin
                    if (!beat_v_r) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = FLUSH;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = DONE;
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            start_ready_r <= (next_state_s == IDLE);
            in_ready_r    <= (next_state_s == ACCUM);
            out_valid_r   <= (next_state_s == DONE);
        end
    end

    // Beat counter and operand capture register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {LEN_WIDTH{1'b0}};
            beat_v_r <= 1'b0;
            a_r      <= {(LANES*DATA_WIDTH){1'b0}};
            b_r      <= {(LANES*DATA_WIDTH){1'b0}};
        end else if (Clr) begin
            cnt_r    <= {LEN_WIDTH{1'b0}};
            beat_v_r <= 1'b0;
        end else begin
            beat_v_r <= accept_s;
            if (start_go_s) begin
                cnt_r <= len;
            end else if (accept_s) begin
                cnt_r <= cnt_r - LEN_WIDTH'(1'b1);
            end
            if (accept_s) begin
                a_r <= Ain;
                b_r <= Bin;
            end
        end
    end

    // Accumulator, sticky overflow and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= {ACC_WIDTH{1'b0}};
            ovf_r  <= 1'b0;
            cout_r <= {ACC_WIDTH{1'b0}};
        end else if (Clr || start_go_s) begin
            acc_r  <= {ACC_WIDTH{1'b0}};
            ovf_r  <= 1'b0;
            cout_r <= {ACC_WIDTH{1'b0}};
        end else begin
            acc_r <= acc_next_s;
            ovf_r <= ovf_next_s;
            if ((state_r == FLUSH) && (next_state_s == DONE)) begin
                cout_r <= acc_next_s;
            end
        end
    end

    assign start_ready = start_ready_r;
    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign Cout        = cout_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_mac_vector_unit.sv
// Scoreboard bench for mac_vector_unit: directed runs push expected results, a monitor checks them.
module tb_mac_vector_unit;

    localparam int DW = 8;
    localparam int L  = 4;
    localparam int AW = 24;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [LW-1:0]   len;
    logic            start_ready;
    logic            Clr;
    logic            in_valid;
    logic            in_ready;
    logic [L*DW-1:0] Ain, Bin;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   Cout;
    logic            overflow;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            beats_acc = 0;
    logic [AW:0]   exp_q [$];

    mac_vector_unit #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .start_ready(start_ready),
        .Clr(Clr), .in_valid(in_valid), .in_ready(in_ready), .Ain(Ain), .Bin(Bin),
        .out_valid(out_valid), .out_ready(out_ready), .Cout(Cout), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic logic [L*DW-1:0] vec(input int a0, input int a1, input int a2, input int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    // Monitor: counts accepted beats and checks each presented result against the scoreboard.
    always @(negedge clk) begin
        logic [AW:0] e;
        if (rst_n && in_valid && in_ready) beats_acc++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                timeout_fail("unexpected_result");
            end else begin
                e = exp_q.pop_front();
                check("result_cout", 32'(Cout), 32'(e[AW-1:0]));
                check("result_ovf", 32'(overflow), 32'(e[AW]));
            end
        end
    end

    task automatic do_start(input int n, input logic [AW:0] e, input bit push);
        start = 1'b1;
        len   = LW'(n);
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [L*DW-1:0] a, input logic [L*DW-1:0] b);
        int t;
        in_valid = 1'b1;
        Ain = a;
        Bin = b;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (t >= 20) timeout_fail("in_ready_wait");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!start_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) timeout_fail("idle_wait");
        @(posedge clk); #1;
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (t >= 50) timeout_fail("out_valid_wait");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; Clr = 1'b0; in_valid = 1'b0;
        Ain = '0; Bin = '0; out_ready = 1'b1;
        #12;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_in_ready",    32'(in_ready),    32'd0);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_cout",        32'(Cout),        32'd0);
        check("rst_overflow",    32'(overflow),    32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // len=1 basic dot product and result latency
        do_start(1, {1'b0, 24'd70}, 1'b1);
        send_beat(vec(1, 2, 3, 4), vec(5, 6, 7, 8));
        @(negedge clk); check("t1_ov_k0", 32'(out_valid), 32'd0);
        @(negedge clk); check("t1_ov_k1", 32'(out_valid), 32'd0);
        @(negedge clk); check("t1_ov_k2", 32'(out_valid), 32'd1);
        wait_idle();

        // len=3 max operands with in_valid gaps
        do_start(3, {1'b0, 24'd780300}, 1'b1);
        beats_acc = 0;
        for (int i = 0; i < 3; i++) begin
            send_beat(vec(255, 255, 255, 255), vec(255, 255, 255, 255));
            @(posedge clk); #1;
        end
        wait_idle();
        check("t2_beats", 32'(beats_acc), 32'd3);

        // len=255 overflow run
`ifdef MAC_SATURATE_EN
        do_start(255, {1'b1, 24'd16777215}, 1'b1);
`else
        do_start(255, {1'b1, 24'd15993852}, 1'b1);
`endif
        for (int i = 0; i < 255; i++) begin
            send_beat(vec(255, 255, 255, 255), vec(255, 255, 255, 255));
        end
        wait_idle();

        // result back-pressure: stable outputs, start ignored
        out_ready = 1'b0;
        do_start(1, {1'b0, 24'd12}, 1'b1);
        send_beat(vec(1, 1, 1, 1), vec(3, 3, 3, 3));
        wait_out_valid();
        start = 1'b1;
        len   = 8'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_ov_stable",   32'(out_valid),   32'd1);
            check("t4_cout_stable", 32'(Cout),        32'd12);
            check("t4_start_rdy",   32'(start_ready), 32'd0);
        end
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_back_idle", 32'(start_ready), 32'd1);
        check("t4_no_accum",  32'(in_ready),    32'd0);
        @(posedge clk); #1;

        // Clr abort after 2 of 4 beats, then a fresh run
        do_start(4, '0, 1'b0);
        send_beat(vec(9, 9, 9, 9), vec(9, 9, 9, 9));
        send_beat(vec(9, 9, 9, 9), vec(9, 9, 9, 9));
        Clr = 1'b1;
        @(posedge clk); #1;
        Clr = 1'b0;
        @(negedge clk);
        check("t5_clr_start_rdy", 32'(start_ready), 32'd1);
        check("t5_clr_in_rdy",    32'(in_ready),    32'd0);
        check("t5_clr_out_valid", 32'(out_valid),   32'd0);
        @(posedge clk); #1;
        do_start(1, {1'b0, 24'd16}, 1'b1);
        send_beat(vec(2, 2, 2, 2), vec(2, 2, 2, 2));
        wait_idle();

        // len=0 result next cycle
        do_start(0, {1'b0, 24'd0}, 1'b1);
        @(negedge clk);
        check("t6_len0_ov", 32'(out_valid), 32'd1);
        wait_idle();

        // async reset mid-ACCUM
        do_start(5, '0, 1'b0);
        send_beat(vec(7, 7, 7, 7), vec(7, 7, 7, 7));
        send_beat(vec(7, 7, 7, 7), vec(7, 7, 7, 7));
        in_valid = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready",    32'(in_ready),    32'd0);
        check("rst_mid_start_ready", 32'(start_ready), 32'd1);
        check("rst_mid_out_valid",   32'(out_valid),   32'd0);
        check("rst_mid_overflow",    32'(overflow),    32'd0);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // clean run after reset
        do_start(1, {1'b0, 24'd70}, 1'b1);
        send_beat(vec(1, 2, 3, 4), vec(5, 6, 7, 8));
        wait_idle();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_vector_unit.md
# mac_vector_unit

Parametrised successor to the single-lane MAC. It accumulates the dot product of two LANES-wide unsigned vectors over a programmable number of beats, using a two-stage multiply/reduce pipeline. Input, start and result transfers each use a valid/ready handshake. It sits between the operand buffers and the result writeback in the minilab datapath.

## Interface
- DATA_WIDTH, 8, width of each unsigned lane operand
- LANES, 4, number of parallel multipliers
- ACC_WIDTH, 24, accumulator and result width; must be at least 2*DATA_WIDTH+clog2(LANES)
- LEN_WIDTH, 8, width of beat-count field
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new dot product
- len  in  LEN_WIDTH  beats in this dot product, 0..2^LEN_WIDTH-1
- start_ready  out  1  high only in IDLE
- Clr  in  1  synchronous abort; returns to IDLE and zeroes the accumulator
- in_valid  in  1  operand beat valid
- in_ready  out  1  high only in ACCUM
- Ain  in  LANES*DATA_WIDTH  lane operands, lane 0 in LSBs
- Bin  in  LANES*DATA_WIDTH  lane operands, lane 0 in LSBs
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- Cout  out  ACC_WIDTH  dot-product result
- overflow  out  1  accumulation exceeded ACC_WIDTH during this run

## Operation
- Reset values: state IDLE, start_ready=1, in_ready=0, out_valid=0, Cout=0, overflow=0, accumulator=0, pipeline valids=0.
- FSM states: IDLE, ACCUM, FLUSH, DONE.
- IDLE: on start, latch len and zero the accumulator and overflow.
  - len=0 goes directly to DONE with Cout=0.
  - Any other len goes to ACCUM with beat counter = len.
- ACCUM: each in_valid&&in_ready edge accepts one beat and decrements the counter. The edge accepting the last beat moves to FLUSH.
- FLUSH: waits until the pipeline valid bits clear, then moves to DONE.
- DONE: out_valid=1 and Cout holds the accumulator.
  - out_valid&&out_ready returns to IDLE.
  - Cout and overflow stay stable until that transfer.
- Arithmetic: all unsigned.
  - Stage 1 registers LANES products of 2*DATA_WIDTH bits each.
  - Stage 2 sums them in an adder tree of width 2*DATA_WIDTH+clog2(LANES), zero-extends to ACC_WIDTH+1 and adds to the accumulator.
  - Bit ACC_WIDTH of that sum sets overflow, which is sticky for the run.
- Clr in any state forces IDLE on the next edge. It zeroes the accumulator, Cout, overflow and pipeline valids. Clr has priority over start and over handshakes on the same edge.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored.

## Timing
- Beat accepted at edge k: product registered at k+1, accumulator updated at k+2.
- Full throughput: one beat per cycle, with no bubbles while in_valid stays high.
- The last beat is accepted at edge k. out_valid rises after edge k+2, so it is visible in the cycle following k+2.
- len=0: out_valid is high the cycle after the start edge.
- Back-to-back runs: start_ready rises the cycle after the result transfer. Minimum run turnaround is len+4 cycles.
- in_valid gaps insert pipeline bubbles only. The result is unchanged.
- rst_n assertion mid-run clears everything asynchronously. No partial result is ever presented.

## Configuration
- MAC_SATURATE_EN defined: on overflow, the accumulator clamps to 2^ACC_WIDTH-1 and stays clamped for the rest of the run. overflow=1.
- MAC_SATURATE_EN undefined: the accumulator wraps modulo 2^ACC_WIDTH. overflow is still flagged.

## Structure
- Package mac_pkg holds:
  - the state enum typedef (IDLE/ACCUM/FLUSH/DONE);
  - a function computing the reduction width from DATA_WIDTH and LANES;
  - the default parameter constants.
- Sub-module mac_lane_mult: one registered DATA_WIDTH×DATA_WIDTH unsigned multiplier with a valid bit, instantiated LANES times in a generate loop. The adder tree, accumulator and FSM live in the top module.

## Test plan
- len=1, Ain lanes {1,2,3,4}, Bin lanes {5,6,7,8}, out_ready=1 -> Cout=70 and overflow=0. out_valid is high the cycle after edge k+2.
- len=3, all lanes 255×255, in_valid toggling every other cycle -> Cout=780300, overflow=0, and exactly 3 beats accepted.
- len=255, all lanes 255×255 -> with MAC_SATURATE_EN: Cout=16777215 and overflow=1. Without the macro: Cout=15993852 and overflow=1.
- Result ready, out_ready held low 5 cycles -> Cout and out_valid stable throughout, start_ready=0, start ignored. The transfer happens on the first out_ready=1 edge.
- Clr asserted after 2 of 4 beats, then len=1 run with {2,2,2,2}×{2,2,2,2} -> Cout=16.
- len=0 -> Cout=0 the next cycle. rst_n pulsed low mid-ACCUM -> all outputs return to reset values immediately.
